// File: rtl/fetch_scheduler_mt.sv
// fetch_scheduler_mt
//   Multithreaded IF-stage front-end. Keeps one PC per hardware thread,
//   picks a runnable thread each cycle round-robin, issues the fetch to the
//   I-side (I-TLB + I-cache), and registers hits into the IF/ID register.
//   Misses, ID back-pressure, redirects and exceptions roll back or
//   overwrite the owning thread's PC.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/pc/thread       registered fetch request to the I-side
//   rsp_miss, rsp_instr       I-side result in the same cycle as req_valid
//   fill_en/fill_thread       miss serviced, clears that thread's stall
//   redirect_en/thread/pc     control-flow redirect from a later stage
//   exc_en/exc_thread         exception, thread restarts at EXC_PC
//   id_ready                  ID accepts a new instruction this cycle
//   id_valid/pc/instr/thread  IF/ID register
//   stalled                   per-thread stall bits
module fetch_scheduler_mt #(
  parameter int              N_THREADS = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_1000,
  parameter logic [XLEN-1:0] EXC_PC    = 32'h0000_2000,
  localparam int             TW        = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_valid,
  output logic [XLEN-1:0]      req_pc,
  output logic [TW-1:0]        req_thread,
  input  logic                 rsp_miss,
  input  logic [XLEN-1:0]      rsp_instr,
  input  logic                 fill_en,
  input  logic [TW-1:0]        fill_thread,
  input  logic                 redirect_en,
  input  logic [TW-1:0]        redirect_thread,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 exc_en,
  input  logic [TW-1:0]        exc_thread,
  input  logic                 id_ready,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_pc,
  output logic [XLEN-1:0]      id_instr,
  output logic [TW-1:0]        id_thread,
  output logic [N_THREADS-1:0] stalled
);

  logic [XLEN-1:0]      pc_q [N_THREADS];
  logic [XLEN-1:0]      pc_d [N_THREADS];
  logic [N_THREADS-1:0] stalled_q, stalled_d;
  logic [TW-1:0]        last_q, last_d;
  logic                 req_valid_q, req_valid_d;
  logic [XLEN-1:0]      req_pc_q, req_pc_d;
  logic [TW-1:0]        req_thread_q, req_thread_d;
  logic                 id_valid_q, id_valid_d;
  logic [XLEN-1:0]      id_pc_q, id_pc_d;
  logic [XLEN-1:0]      id_instr_q, id_instr_d;
  logic [TW-1:0]        id_thread_q, id_thread_d;

  logic [N_THREADS-1:0] eligible;
  logic                 grant_found;
  logic [TW-1:0]        grant_thread;
  logic                 grant;
  logic                 killed;
  logic                 rollback;
  logic                 set_stall;

  // A thread may be picked only if it is not waiting on a miss, has no
  // request already in flight, and is not being overwritten this cycle.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      eligible[t] = !stalled_q[t]
                 && !(req_valid_q && (req_thread_q == TW'(t)))
                 && !(exc_en && (exc_thread == TW'(t)))
                 && !(redirect_en && (redirect_thread == TW'(t)));
    end
  end

  // Round-robin search starting one past the last granted thread.
  always_comb begin : p_search
    logic [TW-1:0] cand;
    grant_found  = 1'b0;
    grant_thread = '0;
    cand         = '0;
    for (int i = 1; i <= N_THREADS; i++) begin
      cand = TW'((int'(last_q) + i) % N_THREADS);
      if (!grant_found && eligible[cand]) begin
        grant_found  = 1'b1;
        grant_thread = cand;
      end
    end
  end

  assign grant  = id_ready && grant_found;
  assign killed = (exc_en && (exc_thread == req_thread_q))
               || (redirect_en && (redirect_thread == req_thread_q));

  always_comb begin
    for (int t = 0; t < N_THREADS; t++) pc_d[t] = pc_q[t];
    stalled_d    = stalled_q;
    last_d       = last_q;
    req_valid_d  = 1'b0;
    req_pc_d     = req_pc_q;
    req_thread_d = req_thread_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_thread_d  = id_thread_q;
    rollback     = 1'b0;
    set_stall    = 1'b0;

    if (grant) begin
      req_valid_d  = 1'b1;
      req_pc_d     = pc_q[grant_thread];
      req_thread_d = grant_thread;
      last_d       = grant_thread;
    end

    if (req_valid_q) begin
      if (killed) begin
        id_valid_d = 1'b0;
      end else if (rsp_miss) begin
        set_stall  = 1'b1;
        rollback   = 1'b1;
        id_valid_d = 1'b0;
      end else if (id_ready) begin
        id_valid_d  = 1'b1;
        id_pc_d     = req_pc_q;
        id_instr_d  = rsp_instr;
        id_thread_d = req_thread_q;
      end else begin
        // ID is full: replay this fetch later, keep the IF/ID contents.
        rollback = 1'b1;
      end
    end else if (id_ready) begin
      id_valid_d = 1'b0;
    end

    // Later assignments win: grant < rollback < redirect < exception.
    // The granted thread is never the in-flight one, so grant and
    // rollback never touch the same PC.
    for (int t = 0; t < N_THREADS; t++) begin
      if (grant && (grant_thread == TW'(t)))          pc_d[t] = pc_q[t] + XLEN'(4);
      if (rollback && (req_thread_q == TW'(t)))       pc_d[t] = req_pc_q;
      if (redirect_en && (redirect_thread == TW'(t))) pc_d[t] = redirect_pc;
      if (exc_en && (exc_thread == TW'(t)))           pc_d[t] = EXC_PC;
      if (fill_en && (fill_thread == TW'(t)))         stalled_d[t] = 1'b0;
      if (set_stall && (req_thread_q == TW'(t)))      stalled_d[t] = 1'b1;
      if (exc_en && (exc_thread == TW'(t)))           stalled_d[t] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) pc_q[t] <= RESET_PC;
      stalled_q    <= '0;
      last_q       <= TW'(N_THREADS - 1);
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      req_thread_q <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
      id_thread_q  <= '0;
    end else begin
      for (int t = 0; t < N_THREADS; t++) pc_q[t] <= pc_d[t];
      stalled_q    <= stalled_d;
      last_q       <= last_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      req_thread_q <= req_thread_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_thread_q  <= id_thread_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_pc     = req_pc_q;
  assign req_thread = req_thread_q;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_instr   = id_instr_q;
  assign id_thread  = id_thread_q;
  assign stalled    = stalled_q;

endmodule

// File: doc/fetch_scheduler_mt.md
# fetch_scheduler_mt

Parametrised multithreaded instruction-fetch front-end for the IF stage. It holds one PC per hardware thread and picks a thread each cycle by round-robin, skipping threads that are stalled. It issues fetch requests to the I-side (I-TLB + I-cache) and registers hits into the IF/ID outputs. On a miss, redirect, exception or ID back-pressure it rolls back or replays the thread's PC.

## Interface
- `N_THREADS`, 4 — hardware threads, ≥1; `TW = max(1, $clog2(N_THREADS))`.
- `XLEN`, 32 — PC/instruction width.
- `RESET_PC`, 32'h0000_1000 — PC of every thread after reset.
- `EXC_PC`, 32'h0000_2000 — exception handler PC.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  out  1  fetch request valid (registered).
- `req_pc`  out  XLEN  virtual PC to fetch (registered).
- `req_thread`  out  TW  requesting thread (registered).
- `rsp_miss`  in  1  I-side result for the current request: 1 = I-TLB or I-cache miss; same cycle as `req_valid`.
- `rsp_instr`  in  XLEN  instruction word; valid when `req_valid && !rsp_miss`.
- `fill_en`, `fill_thread`  in  1, TW  miss serviced; clears that thread's stall.
- `redirect_en`, `redirect_thread`, `redirect_pc`  in  1, TW, XLEN  control-flow redirect from a later stage.
- `exc_en`, `exc_thread`  in  1, TW  exception; thread jumps to `EXC_PC`.
- `id_ready`  in  1  ID can accept a new instruction this cycle.
- `id_valid`, `id_pc`, `id_instr`, `id_thread`  out  1, XLEN, XLEN, TW  IF/ID register.
- `stalled`  out  N_THREADS  per-thread stall bits.

## Operation
- State: `pc[N_THREADS]`, `stalled`, round-robin pointer `last`, plus the request and ID output registers.
- Eligibility of thread t: `!stalled[t]`, no request in flight for t (`!(req_valid && req_thread==t)`), and not the target of `exc_en`/`redirect_en` this cycle.
- Grant: only when `id_ready`. Search starts at `last+1`, wraps modulo N_THREADS, and takes the first eligible thread. On a grant: `req_valid<=1`, `req_pc<=pc[t]`, `req_thread<=t`, `pc[t]<=pc[t]+4`, `last<=t`. With no eligible thread or `!id_ready`: `req_valid<=0`.
- Response resolution, at the edge ending any cycle with `req_valid`; t = `req_thread`:
  - killed (exc or redirect to t this cycle): discard; `id_valid<=0`.
  - `rsp_miss`: `stalled[t]<=1`, `pc[t]<=req_pc`; `id_valid<=0`.
  - hit with `id_ready`: `id_valid<=1`, `id_pc<=req_pc`, `id_instr<=rsp_instr`, `id_thread<=t`.
  - hit with `!id_ready` (replay): `pc[t]<=req_pc`; ID registers hold their value.
- Without `req_valid`: `id_valid<=0` if `id_ready`, else hold.
- PC update priority per thread, highest first: exc (`pc<=EXC_PC`, `stalled<=0`) > redirect (`pc<=redirect_pc`; stall bit unchanged) > miss/replay rollback > grant increment.
- Stall priority: `fill_en` and a miss on the same thread in the same cycle → stall set wins (the new miss). `exc_en` on a thread also clears its stall.
- PC addition wraps modulo 2^XLEN. `redirect_pc` is taken as-is, with no alignment check.

## Timing
- Reset (async assert, sync release): every `pc=RESET_PC`, `stalled=0`, `last=N_THREADS-1` (so thread 0 is granted first), `req_valid=0`, `req_pc=0`, `req_thread=0`, `id_valid=0`, `id_pc=0`, `id_instr=0`, `id_thread=0`.
- Reset asserted mid-operation drops any in-flight request immediately; no ID output is produced for it.
- Latency: grant at edge k → request visible in cycle k..k+1 → `id_*` valid after edge k+1.
- Throughput: one instruction per cycle with ≥2 runnable threads. A single runnable thread gets one instruction per 2 cycles, because of the in-flight exclusion.
- `exc_en`/`redirect_en` take effect at the next edge; the first fetch at the new PC is granted at the edge after that.

## Test plan
- Reset, N=4, all hits, `id_ready=1` → `id_*` sequence (t0,0x1000),(t1,0x1000),(t2,0x1000),(t3,0x1000),(t0,0x1004), one per cycle.
- t1 request at 0x1000 returns `rsp_miss` → `stalled=4'b0010`, t1 skipped (t0,t2,t3 rotate); after `fill_en`/`fill_thread=1`, t1 fetches 0x1000 again.
- `redirect_en` for t2 to 0x4000 in the cycle t2's 0x1000 request is out → no ID output for it; t2's next fetch is 0x4000.
- `exc_en` and `redirect_en` on t3 in the same cycle while t3 is stalled → `pc[3]=0x2000`, `stalled[3]=0`, next t3 fetch at 0x2000.
- `id_ready=0` for 3 cycles during a hit on t0 at 0x1004 → ID registers hold, no grants; after release t0 refetches 0x1004, no instruction lost or duplicated.
- N_THREADS=1 → `req_valid` alternates 1,0; `id_pc` 0x1000,0x1004,0x1008 every 2 cycles.
